ifu_prefetch: RTL
=================

# ifu_prefetch

Parametrised instruction-fetch unit with a prefetch queue, replacing the fixed single-cycle fetch path between instruction ROM and the ifu_de pipeline register. Issues sequential word fetches over a request/grant/response handshake that tolerates variable ROM latency, and buffers up to DEPTH instructions with their PCs. Drops all queued and in-flight fetches when ctrl redirects on a taken jump. Delivers one instruction per cycle to decode under a valid/ready handshake.

## Interface
- ADDR_W, default 32: PC / ROM address width.
- INST_W, default 32: instruction width.
- DEPTH, default 4: queue entries; power of two, ≥2.
- RESET_PC, default 32'h0000_0000: first fetch address after reset.
- clk  in  1  core clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rom_req_o  out  1  fetch request valid.
- rom_addr_o  out  ADDR_W  fetch address, word aligned.
- rom_gnt_i  in  1  request accepted this cycle.
- rom_rvalid_i  in  1  response valid; responses return in request order.
- rom_rdata_i  in  INST_W  response instruction.
- jump_flag_i  in  1  redirect (from ctrl); one-cycle pulse or held.
- jump_addr_i  in  ADDR_W  redirect target.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  INST_W  queue head instruction.
- pc_o  out  ADDR_W  PC of inst_o.
- inst_ready_i  in  1  decode accepts head (deasserted = stall).

## Operation
- State: fetch_pc, resp_pc, queue (occupancy 0..DEPTH), pending (granted, not yet returned), discard (≤ pending).
- rom_req_o = !jump_flag_i && (occupancy + pending < DEPTH); rom_addr_o = fetch_pc. Credit rule guarantees every response has a free slot; no back-pressure on rom_rvalid_i.
- Grant (rom_req_o && rom_gnt_i): fetch_pc += 4, pending += 1.
- Response: pending −= 1; if discard > 0, discard −= 1 and data dropped; else push {resp_pc, rom_rdata_i}, resp_pc += 4.
- Pop: inst_valid_o && inst_ready_i removes head.
- Redirect (jump_flag_i): queue cleared; fetch_pc and resp_pc := {jump_addr_i[ADDR_W-1:2], 2'b00}; discard := pending − rom_rvalid_i (response in the same cycle is dropped); no request issued that cycle; inst_valid_o forced 0 that cycle.
- Simultaneous events: redirect beats push and pop; push and pop same cycle keep occupancy; grant and response same cycle keep pending.
- Address arithmetic wraps modulo 2^ADDR_W without flagging.
- Reset: fetch_pc = resp_pc = RESET_PC; occupancy, pending, discard = 0; rom_req_o = 0 while rst_n low; inst_valid_o = 0, inst_o = 0, pc_o = 0. Reset mid-transfer discards everything; ROM responses to pre-reset requests after release are not permitted (ROM shares rst_n).

## Timing
- First request in the first cycle after rst_n deasserts.
- Response in cycle N → inst_valid_o in N+1 (registered queue, no bypass).
- 1-cycle ROM, ready held high: sustained 1 instruction/cycle, fill latency 2 cycles.
- Redirect in cycle N → request to target in N+1 → first target instruction on inst_o no earlier than N+3.
- inst_o/pc_o stable while inst_valid_o && !inst_ready_i.

## Structure
- core_pkg: ADDR_W/INST_W defaults, INST_NOP (32'h0000_0013), PC_STEP (4).
- Sub-module sync_fifo (WIDTH = ADDR_W+INST_W, DEPTH, synchronous clear), reused by later buffered stages; counters and PCs in ifu_prefetch.

## Test plan
- Reset release, 1-cycle ROM, ready=1 → addresses 0x0,0x4,0x8… every cycle; inst_valid_o from cycle 2; pc_o tracks inst_o.
- inst_ready_i low 10 cycles, DEPTH=4 → exactly 4 queued, rom_req_o drops once occupancy+pending=4, head held; ready restored → 4 pops in order, no loss or duplicate.
- 3-cycle ROM latency, 2 pending, jump to 0x100 → 2 late responses dropped, next inst_o is from 0x100 with pc_o=0x100.
- Jump with response and pop in same cycle, jump_addr 0x203 → response dropped, queue empty next cycle, fetch at 0x200.
- rom_gnt_i toggled randomly, random rvalid delays → in-order PC sequence, occupancy+pending never exceeds DEPTH.
- rst_n asserted mid-stream with full queue → all outputs reset immediately; refetch starts at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared constants for the instruction-fetch prefetch unit
//
// Purpose : default widths, PC step and NOP encoding shared by the fetch path
//           and later buffered stages.
// Ports   : none (package).
package ifu_prefetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned INST_W_DEF = 32;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam int unsigned PC_STEP    = 4;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - ROM fetch bus, redirect and decode handshake bundle
//
// Purpose : groups the ROM request/grant/response bus, the ctrl redirect and
//           the decode valid/ready handshake seen by ifu_prefetch.
// Ports   : master = prefetch unit side, slave = ROM/ctrl/decode side.
//   rom_req_o/rom_addr_o            fetch request and word address
//   rom_gnt_i                       request accepted this cycle
//   rom_rvalid_i/rom_rdata_i        in-order response
//   jump_flag_i/jump_addr_i         redirect from ctrl
//   inst_valid_o/inst_o/pc_o        queue head to decode
//   inst_ready_i                    decode accepts head
interface ifu_prefetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);

  logic              rom_req_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_gnt_i;
  logic              rom_rvalid_i;
  logic [INST_W-1:0] rom_rdata_i;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              inst_ready_i;

  modport master (
    output rom_req_o, rom_addr_o, inst_valid_o, inst_o, pc_o,
    input  rom_gnt_i, rom_rvalid_i, rom_rdata_i, jump_flag_i, jump_addr_i,
           inst_ready_i
  );

  modport slave (
    input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, pc_o,
    output rom_gnt_i, rom_rvalid_i, rom_rdata_i, jump_flag_i, jump_addr_i,
           inst_ready_i
  );

endinterface

// File: rtl/ifu_prefetch_sync_fifo.sv
// rtl/ifu_prefetch_sync_fifo.sv - synchronous FIFO with clear, no read bypass
//
// Purpose : registered FIFO used as the prefetch queue; reusable by later
//           buffered stages.
// Ports   :
//   clk, rst_n         clock, asynchronous active-low reset
//   clr_i              synchronous clear; overrides push and pop
//   push_i, wdata_i    write (ignored when full)
//   pop_i              remove head (ignored when empty)
//   rdata_o            head entry (meaningful only when !empty_o)
//   empty_o, full_o    status
//   count_o            occupancy 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when count_q says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit with credit-based ROM fetch
//
// Purpose : issues sequential word fetches to ROM, buffers up to DEPTH
//           {pc, instruction} pairs, drops queued and in-flight fetches on a
//           redirect and hands one instruction per cycle to decode.
// Ports   :
//   clk, rst_n   core clock, asynchronous active-low reset
//   bus          ifu_prefetch_if master: ROM bus, redirect, decode handshake
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  ifu_prefetch_if.master bus
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
  logic [CNT_W-1:0]  pending_q,  pending_d;
  logic [CNT_W-1:0]  discard_q,  discard_d;

  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W:0]    in_use;
  logic [ADDR_W-1:0] jump_target;
  logic [ENT_W-1:0]  head;
  logic              empty;
  logic              full_unused;
  logic              jump, resp, grant, push, pop;

  assign jump        = bus.jump_flag_i;
  assign resp        = bus.rom_rvalid_i;
  assign jump_target = {bus.jump_addr_i[ADDR_W-1:2], 2'b00};

  // Credit rule: every outstanding request already owns a queue slot, so a
  // response can always be pushed without back-pressuring the ROM. Slots held
  // by requests that will be discarded still count; this is conservative.
  assign in_use        = (CNT_W + 1)'(occupancy) + (CNT_W + 1)'(pending_q);
  assign bus.rom_req_o = rst_n && !jump && (in_use < CREDIT_MAX);
  assign bus.rom_addr_o = fetch_pc_q;

  assign grant = bus.rom_req_o && bus.rom_gnt_i;
  assign push  = resp && (discard_q == '0) && !jump;

  assign bus.inst_valid_o = !jump && !empty;
  assign pop              = bus.inst_valid_o && bus.inst_ready_i;
  assign bus.inst_o       = empty ? '0 : head[INST_W-1:0];
  assign bus.pc_o         = empty ? '0 : head[ENT_W-1:INST_W];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    pending_d  = pending_q;
    discard_d  = discard_q;

    if (grant && !resp)      pending_d = pending_q + CNT_W'(1);
    else if (!grant && resp) pending_d = pending_q - CNT_W'(1);

    if (jump) begin
      fetch_pc_d = jump_target;
      resp_pc_d  = jump_target;
      // A response arriving in the redirect cycle is already dropped here,
      // so it must not be counted again as a future discard.
      discard_d  = pending_q - CNT_W'(resp);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + STEP;
      if (push)  resp_pc_d  = resp_pc_q + STEP;
      if (resp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      pending_q  <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (jump),
    .push_i  (push),
    .wdata_i ({resp_pc_q, bus.rom_rdata_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full_unused),
    .count_o (occupancy)
  );

endmodule
